// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: datapath defaults, load-size
// encodings and the write-back stage occupancy states.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Little-endian sub-word load extraction with zero/sign extension.
// Encoding 2'b11 of loadSize behaves as a full word.
module load_extend
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] memData,
    input  logic [1:0]        addr,
    input  logic [1:0]        loadSize,
    input  logic              loadSigned,
    output logic [DATA_W-1:0] extData
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = memData[7:0];
            2'd1:    byte_sel = memData[15:8];
            2'd2:    byte_sel = memData[23:16];
            default: byte_sel = memData[31:24];
        endcase
        // Halfword alignment ignores addr[0].
        half_sel = addr[1] ? memData[31:16] : memData[15:0];
    end

    always_comb begin
        case (loadSize)
            LS_BYTE: extData = {{(DATA_W-8){loadSigned & byte_sel[7]}}, byte_sel};
            LS_HALF: extData = {{(DATA_W-16){loadSigned & half_sel[15]}}, half_sel};
            default: extData = memData;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: output register plus one skid entry so inReady is registered.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] memData,
    input  logic [REG_AW-1:0] destReg,
    input  logic              regWrite,
    input  logic              memToReg,
    input  logic [1:0]        loadSize,
    input  logic              loadSigned,
    input  logic              wbHold,
    output logic [DATA_W-1:0] writeToReg,
    output logic [REG_AW-1:0] finRD,
    output logic              writeSig,
    output logic              fwdValid,
    output logic [REG_AW-1:0] fwdReg,
    output logic [DATA_W-1:0] fwdData
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retireCount
`endif
);

    wb_state_e         state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic [REG_AW-1:0] out_rd_q, out_rd_d, skid_rd_q, skid_rd_d;
    logic              out_wr_q, out_wr_d, skid_wr_q, skid_wr_d;

    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] in_data;
    logic              accept;
    logic              retire;
    logic              out_valid;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .memData    (memData),
        .addr       (aluResult[1:0]),
        .loadSize   (loadSize),
        .loadSigned (loadSigned),
        .extData    (ext_data)
    );

    assign in_data   = memToReg ? ext_data : aluResult;
    assign out_valid = (state_q != EMPTY);
    assign accept    = inValid && in_ready_q;
    assign retire    = out_valid && !wbHold;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_wr_d    = out_wr_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_wr_d   = skid_wr_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    out_data_d = in_data;
                    out_rd_d   = destReg;
                    out_wr_d   = regWrite;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    out_data_d = in_data;
                    out_rd_d   = destReg;
                    out_wr_d   = regWrite;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_data_d = in_data;
                    skid_rd_d   = destReg;
                    skid_wr_d   = regWrite;
                end else if (retire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (retire) begin
                    state_d    = ONE;
                    out_data_d = skid_data_q;
                    out_rd_d   = skid_rd_q;
                    out_wr_d   = skid_wr_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_wr_q    <= 1'b0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Ready is taken from the next state so it is a clean flop output.
            in_ready_q  <= (state_d != FULL);
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_wr_q    <= out_wr_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_wr_q   <= skid_wr_d;
        end
    end

    assign inReady    = in_ready_q;
    assign writeToReg = out_data_q;
    assign finRD      = out_rd_q;
    assign writeSig   = out_valid && out_wr_q && (out_rd_q != '0) && !wbHold;
    assign fwdValid   = writeSig;
    assign fwdReg     = out_rd_q;
    assign fwdData    = out_data_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retireCount = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a queue-based reference model
// of pending instructions; covers loads, $0 targets, holds and reset while full.
module tb_writeback_stage;
    import mips_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] aluResult;
    logic [31:0] memData;
    logic [4:0]  destReg;
    logic        regWrite;
    logic        memToReg;
    logic [1:0]  loadSize;
    logic        loadSigned;
    logic        wbHold;
    logic [31:0] writeToReg;
    logic [4:0]  finRD;
    logic        writeSig;
    logic        fwdValid;
    logic [4:0]  fwdReg;
    logic [31:0] fwdData;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCount;
`endif

    writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .inValid    (inValid),
        .inReady    (inReady),
        .aluResult  (aluResult),
        .memData    (memData),
        .destReg    (destReg),
        .regWrite   (regWrite),
        .memToReg   (memToReg),
        .loadSize   (loadSize),
        .loadSigned (loadSigned),
        .wbHold     (wbHold),
        .writeToReg (writeToReg),
        .finRD      (finRD),
        .writeSig   (writeSig),
        .fwdValid   (fwdValid),
        .fwdReg     (fwdReg),
        .fwdData    (fwdData)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retireCount(retireCount)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wr;
    } ent_t;

    ent_t        pend_q[$];
    int unsigned retired = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_txn = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Value the register file should receive, from the ISA load rules.
    function automatic logic [31:0] ref_value(input logic [31:0] alu, input logic [31:0] mem,
                                              input logic m2r, input logic [1:0] ls,
                                              input logic sg);
        logic [31:0] v;
        int          sh;
        if (!m2r) return alu;
        if (ls == 2'b10) begin
            sh = int'(alu[1:0]) * 8;
            v  = (mem >> sh) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (ls == 2'b01) begin
            sh = alu[1] ? 16 : 0;
            v  = (mem >> sh) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    task automatic check_outputs();
        logic ws_exp;
        ws_exp = (pend_q.size() > 0) && pend_q[0].wr && (pend_q[0].rd != 5'd0) && !wbHold;
        chk("inReady", inReady, (pend_q.size() < 2));
        chk("writeSig", writeSig, ws_exp);
        chk("fwdValid", fwdValid, ws_exp);
        if (pend_q.size() > 0) begin
            chk("finRD", finRD, pend_q[0].rd);
            chk("writeToReg", writeToReg, pend_q[0].data);
            chk("fwdReg", fwdReg, pend_q[0].rd);
            chk("fwdData", fwdData, pend_q[0].data);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("retireCount", retireCount, retired);
`endif
    endtask

    // One clock: drive inputs, check at negedge, advance the model at posedge.
    task automatic do_cycle(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                            input logic [4:0] rd, input logic rw, input logic m2r,
                            input logic [1:0] ls, input logic sg, input logic hold);
        logic acc;
        logic ret;
        ent_t e;
        inValid    = v;
        aluResult  = alu;
        memData    = mem;
        destReg    = rd;
        regWrite   = rw;
        memToReg   = m2r;
        loadSize   = ls;
        loadSigned = sg;
        wbHold     = hold;
        @(negedge Clk);
        check_outputs();
        acc = v && (pend_q.size() < 2);
        ret = (pend_q.size() > 0) && !hold;
        $display("txn %0d v=%0b hold=%0b acc=%0b ret=%0b rd=%0d alu=%h wsig=%0b wdata=%h",
                 n_txn, v, hold, acc, ret, rd, alu, writeSig, writeToReg);
        n_txn++;
        @(posedge Clk);
        if (ret) begin
            void'(pend_q.pop_front());
            retired++;
        end
        if (acc) begin
            e.data = ref_value(alu, mem, m2r, ls, sg);
            e.rd   = rd;
            e.wr   = rw;
            pend_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic hold);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, hold);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_writeSig"}, writeSig, 32'd0);
        chk({tag, "_writeToReg"}, writeToReg, 32'd0);
        chk({tag, "_finRD"}, finRD, 32'd0);
        chk({tag, "_fwdValid"}, fwdValid, 32'd0);
        chk({tag, "_fwdReg"}, fwdReg, 32'd0);
        chk({tag, "_fwdData"}, fwdData, 32'd0);
        chk({tag, "_inReady"}, inReady, 32'd1);
`ifdef WB_RETIRE_CNT_EN
        chk({tag, "_retireCount"}, retireCount, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] alu;
        logic [4:0]  rd;
        Rst = 1'b1;
        inValid = 1'b0; aluResult = '0; memData = '0; destReg = '0; regWrite = 1'b0;
        memToReg = 1'b0; loadSize = 2'b00; loadSigned = 1'b0; wbHold = 1'b0;
        #12;
        check_reset_values("rst");
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        // Simple ALU write, visible one cycle after acceptance.
        do_cycle(1'b1, 32'h0000_1234, 32'h0, 5'd8, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("alu_writeSig", writeSig, 32'd1);
        chk("alu_finRD", finRD, 32'd8);
        chk("alu_data", writeToReg, 32'h0000_1234);

        // Load extension cases.
        do_cycle(1'b1, 32'h0000_0102, 32'hA1B2_C3D4, 5'd9, 1'b1, 1'b1, LS_BYTE, 1'b1, 1'b0);
        chk("lb_signed", writeToReg, 32'hFFFF_FFB2);
        do_cycle(1'b1, 32'h0000_0102, 32'hA1B2_C3D4, 5'd9, 1'b1, 1'b1, LS_BYTE, 1'b0, 1'b0);
        chk("lb_unsigned", writeToReg, 32'h0000_00B2);
        do_cycle(1'b1, 32'h0000_0103, 32'hA1B2_C3D4, 5'd10, 1'b1, 1'b1, LS_HALF, 1'b1, 1'b0);
        chk("lh_signed", writeToReg, 32'hFFFF_A1B2);

        // $0 target retires without asserting the write.
        do_cycle(1'b1, 32'h0000_5555, 32'h0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("r0_writeSig", writeSig, 32'd0);
        idle(1, 1'b0);

        // Hold with continuous input: second entry lands in the skid buffer.
        do_cycle(1'b1, 32'h0000_0AAA, 32'h0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        do_cycle(1'b1, 32'h0000_0BBB, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("hold_inReady", inReady, 32'd0);
        do_cycle(1'b1, 32'h0000_0CCC, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        idle(3, 1'b0);

        // Back-to-back accepts without hold.
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, 32'h100 + i, 32'h0, 5'(i + 1), 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            chk("b2b_inReady", inReady, 32'd1);
        end
        idle(1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            alu = $urandom;
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_cycle($urandom_range(0, 9) < 8, alu, $urandom, rd, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end
        idle(3, 1'b0);

        // Reset asserted while FULL: nothing from either entry may be written.
        do_cycle(1'b1, 32'h0000_0DDD, 32'h0, 5'd6, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        do_cycle(1'b1, 32'h0000_0EEE, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("full_inReady", inReady, 32'd0);
        wbHold = 1'b0;
        inValid = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        check_reset_values("midrst");
        pend_q.delete();
        retired = 0;
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        idle(4, 1'b0);
        do_cycle(1'b1, 32'h0000_0FFF, 32'h0, 5'd11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        idle(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline stage of the MIPS core: accepts completed instructions from the memory stage, selects and extends the write-back value, and drives the register-file write port (writeToReg, finRD, writeSig) consumed by the decode stage. Includes a 2-entry skid buffer so the memory stage sees a registered ready, and publishes the pending write as a forwarding source.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- Clk  in  1  core clock, all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- inValid  in  1  memory stage presents an instruction
- inReady  out  1  stage can accept; registered
- aluResult  in  DATA_W  ALU result / effective address
- memData  in  DATA_W  raw word read from data memory
- destReg  in  REG_AW  destination register (already RegDST-selected)
- regWrite  in  1  instruction writes a register
- memToReg  in  1  1 = load data, 0 = aluResult
- loadSize  in  2  00 word, 01 half, 10 byte, 11 treated as word
- loadSigned  in  1  sign-extend sub-word load
- wbHold  in  1  freeze output register (debug/hazard unit)
- writeToReg  out  DATA_W  register-file write data
- finRD  out  REG_AW  register-file write address
- writeSig  out  1  register-file write enable
- fwdValid, fwdReg, fwdData  out  1/REG_AW/DATA_W  forwarding copy of pending write
- retireCount  out  32  retired-instruction count (only with WB_RETIRE_CNT_EN)

## Operation
- States: EMPTY (no output entry), ONE (output entry valid), FULL (output + skid entry valid).
- Accept = inValid && inReady. Retire = output entry valid && !wbHold.
- EMPTY: accept -> ONE (load output reg).
- ONE: accept && retire -> ONE (output reloaded); accept && !retire -> FULL (capture in skid); !accept && retire -> EMPTY.
- FULL: retire -> ONE (skid moves to output); otherwise stay. No accept possible (inReady = 0).
- inReady = 1 in EMPTY/ONE, 0 in FULL; registered from next state.
- Data select, applied before registering: memToReg=0 -> aluResult; memToReg=1 -> extended load.
- Load extend, little-endian: byte selected by aluResult[1:0]; half selected by aluResult[1] (bit 0 ignored); word passes unchanged; zero- or sign-extend per loadSigned.
- writeSig = output valid && regWrite && finRD != 0 && !wbHold. Writes to $0 are retired but never asserted.
- fwdValid/fwdReg/fwdData mirror writeSig/finRD/writeToReg exactly.

## Timing
- Latency 1: instruction accepted on edge N shows on writeToReg/finRD/writeSig after edge N; register file commits on edge N+1.
- Skid path adds 1 cycle per hold cycle; no instruction is dropped or duplicated.
- wbHold asserted: output entry frozen, writeSig low; deasserted: write asserted same cycle.
- Reset (any time, including mid-FULL): state EMPTY, all entries invalidated, writeToReg=0, finRD=0, writeSig=0, fwd*=0, retireCount=0, inReady=1 after reset release.

## Configuration
- WB_RETIRE_CNT_EN defined: 32-bit retireCount increments by 1 on each retire (including non-writing instructions and $0 targets); wraps 0xFFFFFFFF -> 0.
- Undefined: counter and port absent; no other behaviour changes.

## Structure
- Shared package mips_pkg: load-size constants (LS_WORD, LS_HALF, LS_BYTE), wb state enum (EMPTY/ONE/FULL), DATA_W/REG_AW defaults.
- One sub-module: load_extend (combinational: memData, addr[1:0], loadSize, loadSigned -> extended word).

## Test plan
- Reset, then single accept aluResult=0x1234, destReg=8, regWrite=1, memToReg=0 -> next cycle writeSig=1, finRD=8, writeToReg=0x00001234, fwd* equal.
- Load byte memData=0xA1B2C3D4, aluResult[1:0]=2, signed -> writeToReg=0xFFFFFFB2; unsigned -> 0x000000B2; half at addr[1]=1 signed -> 0xFFFFA1B2.
- destReg=0, regWrite=1 -> writeSig stays 0; retireCount still increments (with macro).
- wbHold=1 for 3 cycles with inValid continuous -> one entry captured in skid, inReady=0 from second cycle; after release both retire in order, no loss.
- Back-to-back accepts without hold -> one write per cycle, inReady constantly 1.
- Rst asserted while FULL -> immediately writeSig=0, inReady=1 after release, skid contents never written.
